// File: rtl/psg_mixer_pwm.sv
`default_nettype none
// ============================================================================
// Module      : psg_mixer_pwm
// Description : Sums the attenuated PSG channel volumes through a pipelined
//               adder tree. It then drives a 1-bit audio output for an
//               external RC filter.
//               Default build: a glitch-free PWM whose duty value is taken
//               only at period boundaries.
//               MIXER_SIGMA_DELTA_EN defined: the PWM comparator is replaced
//               by a first-order sigma-delta modulator.
// Revision    : 1.0 - initial release
// ============================================================================
module psg_mixer_pwm #(
    parameter int  CHANNELS    = 4,
    parameter int  VOLUME_BITS = 15,
    parameter int  PWM_BITS    = 8,
    localparam int SUM_BITS    = VOLUME_BITS + $clog2(CHANNELS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS*VOLUME_BITS-1:0] ch_volume,
    input  logic [CHANNELS-1:0]             ch_mute,
    output logic [SUM_BITS-1:0]             sum_out,
    output logic                            pwm_out,
    output logic                            period_start
);

    localparam int                  LEVELS   = $clog2(CHANNELS);
    localparam int                  PAD_BITS = SUM_BITS - VOLUME_BITS;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Adder tree
    // Level 0 holds the (possibly muted) channel volumes. Each further
    // level holds the pairwise sums of the level below it. All levels are
    // stored at the full mix width. The values can never exceed
    // CHANNELS * max volume, so the zero-extended upper bits simply stay 0.
    // ------------------------------------------------------------------
    logic [VOLUME_BITS-1:0] vol_in [CHANNELS];
    logic [SUM_BITS-1:0]    tree_q [LEVELS+1][CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign vol_in[i] = ch_volume[i*VOLUME_BITS +: VOLUME_BITS];
    end

    // Input register with muting, followed by one register level per add level
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    tree_q[l][n] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                tree_q[0][n] <= ch_mute[n] ? '0 : {{PAD_BITS{1'b0}}, vol_in[n]};
            end
            for (int l = 1; l <= LEVELS; l++) begin
                for (int n = 0; n < CHANNELS / 2; n++) begin
                    if (n < (CHANNELS >> l)) begin
                        tree_q[l][n] <= tree_q[l-1][2*n] + tree_q[l-1][2*n+1];
                    end
                end
            end
        end
    end

    // The root of the tree is the registered mix
    assign sum_out = tree_q[LEVELS][0];

    // ------------------------------------------------------------------
    // Period counter and duty capture
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_q_next;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] cnt_next;
    logic                period_end;

    // The duty value is the mix truncated to its top PWM_BITS bits
    assign duty       = sum_out[SUM_BITS-1 -: PWM_BITS];
    assign cnt_next   = cnt + CNT_ONE;
    assign period_end = (cnt == CNT_LAST);

    // Free-running period counter. period_start marks the cycle with cnt == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            duty_q       <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            duty_q       <= duty_q_next;
            period_start <= period_end;
        end
    end

`ifdef MIXER_SIGMA_DELTA_EN
    // ------------------------------------------------------------------
    // First-order sigma-delta modulator
    // The duty value follows the mix every cycle. The output is the carry
    // out of the phase accumulator. The accumulator runs freely across
    // period boundaries.
    // ------------------------------------------------------------------
    logic [PWM_BITS:0] acc;
    logic [PWM_BITS:0] acc_next;

    assign duty_q_next = duty;
    assign acc_next    = {1'b0, acc[PWM_BITS-1:0]} + {1'b0, duty_q};

    // Accumulate. The stored carry bit is the registered audio output.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign pwm_out = acc[PWM_BITS];
`else
    // ------------------------------------------------------------------
    // PWM comparator
    // The output is computed from the counter and duty values of the
    // coming cycle. This keeps pwm_out registered while the pulse still
    // starts in the cycle where cnt == 0.
    // ------------------------------------------------------------------
    assign duty_q_next = period_end ? duty : duty_q;

    // Registered comparison of the upcoming counter value against the upcoming duty value
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (cnt_next < duty_q_next);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_psg_mixer_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_psg_mixer_pwm
// Description : Scoreboard bench for psg_mixer_pwm. The stimulus process
//               queues the expected values. A monitor process compares them
//               against the DUT outputs and checks the high time of each
//               PWM period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psg_mixer_pwm;

    localparam int CH = 4;
    localparam int VB = 15;
    localparam int PB = 8;
    localparam int SB = 17;

    localparam int SIG_SUM = 0;
    localparam int SIG_PWM = 1;
    localparam int SIG_PS  = 2;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [CH*VB-1:0] ch_volume = '0;
    logic [CH-1:0]    ch_mute   = '0;
    logic [SB-1:0]    sum_out;
    logic             pwm_out;
    logic             period_start;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   per_q[$];

    psg_mixer_pwm #(
        .CHANNELS    (CH),
        .VOLUME_BITS (VB),
        .PWM_BITS    (PB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_volume    (ch_volume),
        .ch_mute      (ch_mute),
        .sum_out      (sum_out),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle k lies between posedge k and posedge k+1
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    endtask

    // Keep the expectation queue sorted by cycle
    function automatic void push_exp(input int c, input int s, input int v);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endfunction

    function automatic int sample(input int s);
        case (s)
            SIG_SUM: return int'(sum_out);
            SIG_PWM: return int'(pwm_out);
            default: return int'(period_start);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            SIG_SUM: return "sum_out";
            SIG_PWM: return "pwm_out";
            default: return "period_start";
        endcase
    endfunction

    // Monitor: per-cycle expectations plus per-period high-time accounting
    initial begin : monitor
        exp_t e;
        int   high_cnt;
        bit   active;
        bit   seen_low;
        bit   late_high;
        high_cnt  = 0;
        active    = 1'b0;
        seen_low  = 1'b0;
        late_high = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) check({"missed_", sig_name(e.sig)}, cyc, e.cyc);
                else             check(sig_name(e.sig), sample(e.sig), e.val);
            end
            if (reset) begin
                active    = 1'b0;
                high_cnt  = 0;
                seen_low  = 1'b0;
                late_high = 1'b0;
            end else begin
                if (period_start) begin
                    if (active) begin
                        if (per_q.size() == 0) begin
                            check("period_unexpected", high_cnt, -1);
                        end else begin
                            check("period_high_cycles", high_cnt, per_q.pop_front());
`ifndef MIXER_SIGMA_DELTA_EN
                            check("period_pulse_contiguous", int'(late_high), 0);
`endif
                        end
                    end
                    active    = 1'b1;
                    high_cnt  = 0;
                    seen_low  = 1'b0;
                    late_high = 1'b0;
                end
                if (active) begin
                    if (pwm_out) begin
                        high_cnt++;
                        if (seen_low) late_high = 1'b1;
                    end else begin
                        seen_low = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_inputs(input int v0, input int v1, input int v2, input int v3,
                              input logic [CH-1:0] m);
        ch_volume = {VB'(v3), VB'(v2), VB'(v1), VB'(v0)};
        ch_mute   = m;
    endtask

    // Stimulus: reset is released in cycle 3, so period_start pulses at 259 + 256k
    initial begin : stimulus
        wait_until(3);
        push_exp(3, SIG_SUM, 0);
        push_exp(3, SIG_PWM, 0);
        push_exp(3, SIG_PS, 0);
        reset = 1'b0;
`ifdef MIXER_SIGMA_DELTA_EN
        set_inputs('h7FFF, 'h7FFF, 2, 0, 4'b0000);
        push_exp(6, SIG_SUM, 'h10000);
        push_exp(8, SIG_PWM, 0);
        push_exp(9, SIG_PWM, 1);
        push_exp(10, SIG_PWM, 0);
        push_exp(11, SIG_PWM, 1);
        push_exp(258, SIG_PS, 0);
        push_exp(259, SIG_PS, 1);
        per_q.push_back(128);
        per_q.push_back(128);
        wait_until(780);
`else
        set_inputs('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 4'b0000);
        push_exp(6, SIG_SUM, 'h1FFFC);
        push_exp(258, SIG_PS, 0);
        push_exp(259, SIG_PS, 1);
        push_exp(513, SIG_PWM, 1);
        push_exp(514, SIG_PWM, 0);
        per_q.push_back(255);

        wait_until(300);
        set_inputs('h7FFF, 0, 0, 0, 4'b0000);
        push_exp(303, SIG_SUM, 'h07FFF);
        push_exp(577, SIG_PWM, 1);
        push_exp(578, SIG_PWM, 0);
        per_q.push_back(63);

        wait_until(525);
        set_inputs(0, 0, 0, 0, 4'b0000);
        push_exp(528, SIG_SUM, 0);
        per_q.push_back(0);

        wait_until(800);
        set_inputs('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 4'b1111);
        push_exp(803, SIG_SUM, 0);
        per_q.push_back(0);

        wait_until(1100);
        set_inputs('h0001, 'h0100, 'h1000, 'h4000, 4'b0010);
        push_exp(1103, SIG_SUM, 'h05001);
        per_q.push_back(40);

        wait_until(1300);
        set_inputs('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 4'b0101);
        push_exp(1303, SIG_SUM, 'h0FFFE);
        push_exp(1639, SIG_PWM, 1);
        push_exp(1640, SIG_SUM, 0);
        push_exp(1640, SIG_PWM, 0);
        push_exp(1640, SIG_PS, 0);

        wait_until(1639);
        reset = 1'b1;
        wait_until(1641);
        reset = 1'b0;
        push_exp(1643, SIG_SUM, 0);
        push_exp(1644, SIG_SUM, 'h0FFFE);
        push_exp(1700, SIG_PWM, 0);
        push_exp(1896, SIG_PS, 0);
        push_exp(1897, SIG_PS, 1);
        per_q.push_back(127);
        wait_until(2160);
`endif
        check("scoreboard_drained", exp_q.size() + per_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout at cyc %0d, expected finish", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
